hsync_line_decoder: RTL and testbench

HSYNC_LINE_DECODER -- requirements
Module: hsync_line_decoder

---
 rtl/hsync_line_decoder.sv | 91 +++++++++
 tb/tb_hsync_line_decoder.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/hsync_line_decoder.sv
// hsync_line_decoder: recovers line timing (sync width, period, active window) from a low-going hsync sampled on pixel ticks.
// Define HSYNC_DECODER_ERRCNT_EN to implement the saturating lock-loss ErrorCount; otherwise ErrorCount reads 0.
module hsync_line_decoder (
  input  logic       clock,
  input  logic       reset,
  input  logic       PixelClock,
  input  logic       hsync,
  input  logic [9:0] BackPorch,
  input  logic [9:0] ActiveVideo,
  output logic       Locked,
  output logic [9:0] SynchWidth,
  output logic [9:0] LinePeriod,
  output logic       LineStart,
  output logic       ActiveFlag,
  output logic [9:0] xposition,
  output logic [7:0] ErrorCount
);
  typedef enum logic [1:0] {SEARCH, TRAIN, LOCKED} state_t;
  state_t r_state, w_state_nxt;
  logic r_pix_prev, r_hs_prev;
  logic [9:0] r_cnt, r_cand_w;
  logic w_tick, w_start, w_end, w_timeout, w_store, w_match, w_act_nxt;
  logic [9:0] w_cnt_inc, w_cnt_nxt, w_sw_nxt, w_lp_nxt, w_x_nxt;
  logic [10:0] w_lo;
  logic [11:0] w_hi;

  assign w_tick    = PixelClock & ~r_pix_prev;
  assign w_start   = w_tick & r_hs_prev & ~hsync;
  assign w_end     = w_tick & ~r_hs_prev & hsync;
  assign w_cnt_inc = (r_cnt == 10'h3ff) ? r_cnt : r_cnt + 10'd1;
  assign w_cnt_nxt = w_start ? 10'd0 : (w_tick ? w_cnt_inc : r_cnt);
  assign w_timeout = w_tick & ~w_start & (w_cnt_inc == 10'h3ff);
  assign w_store   = w_start & (r_state != SEARCH);
  // Both candidates are the post-increment count: pixels low, and pixels since the previous start.
  assign w_match   = (r_cand_w == SynchWidth) & (w_cnt_inc == LinePeriod);

  always_ff @(posedge clock or negedge reset)
    if (!reset) r_state <= SEARCH;
    else        r_state <= w_state_nxt;

  always_comb
    w_state_nxt = w_timeout ? SEARCH :
                  !w_start ? r_state :
                  (r_state == SEARCH || !w_match) ? TRAIN : LOCKED;

  always_comb begin
    w_sw_nxt  = w_store ? r_cand_w : SynchWidth;
    w_lp_nxt  = w_store ? w_cnt_inc : LinePeriod;
    w_lo      = {1'b0, w_sw_nxt} + {1'b0, BackPorch};
    w_hi      = {1'b0, w_lo} + {2'b0, ActiveVideo};
    w_act_nxt = (w_state_nxt == LOCKED) && ({1'b0, w_cnt_nxt} >= w_lo) && ({2'b0, w_cnt_nxt} < w_hi);
    w_x_nxt   = w_act_nxt ? w_cnt_nxt - w_lo[9:0] : 10'd0;
  end

  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      r_pix_prev <= 1'b0;
      r_hs_prev  <= 1'b0;
      r_cnt      <= 10'd0;
      r_cand_w   <= 10'd0;
      SynchWidth <= 10'd0;
      LinePeriod <= 10'd0;
      Locked     <= 1'b0;
      LineStart  <= 1'b0;
      ActiveFlag <= 1'b0;
      xposition  <= 10'd0;
    end else begin
      r_pix_prev <= PixelClock;
      r_hs_prev  <= w_tick ? hsync : r_hs_prev;
      r_cnt      <= w_cnt_nxt;
      r_cand_w   <= w_end ? w_cnt_inc : r_cand_w;
      SynchWidth <= w_sw_nxt;
      LinePeriod <= w_lp_nxt;
      Locked     <= (w_state_nxt == LOCKED);
      LineStart  <= w_store;
      ActiveFlag <= w_act_nxt;
      xposition  <= w_x_nxt;
    end

`ifdef HSYNC_DECODER_ERRCNT_EN
  logic [7:0] r_err;
  logic w_lock_err;
  assign w_lock_err = (r_state == LOCKED) & (w_timeout | (w_start & ~w_match));
  always_ff @(posedge clock or negedge reset)
    if (!reset) r_err <= 8'd0;
    else if (w_lock_err && r_err != 8'hff) r_err <= r_err + 8'd1;
  assign ErrorCount = r_err;
`else
  assign ErrorCount = 8'd0;
`endif
endmodule

// File: tb/tb_hsync_line_decoder.sv
// tb_hsync_line_decoder: line-level reference model feeds a scoreboard; a monitor checks each LineStart and each active pixel.
`timescale 1ns/100ps
module tb_hsync_line_decoder;
  logic clock = 1'b0, reset = 1'b0, PixelClock = 1'b0, hsync = 1'b1;
  logic [9:0] BackPorch, ActiveVideo;
  logic Locked, LineStart, ActiveFlag;
  logic [9:0] SynchWidth, LinePeriod, xposition;
  logic [7:0] ErrorCount;

  hsync_line_decoder dut (
    .clock(clock), .reset(reset), .PixelClock(PixelClock), .hsync(hsync),
    .BackPorch(BackPorch), .ActiveVideo(ActiveVideo), .Locked(Locked),
    .SynchWidth(SynchWidth), .LinePeriod(LinePeriod), .LineStart(LineStart),
    .ActiveFlag(ActiveFlag), .xposition(xposition), .ErrorCount(ErrorCount)
  );

  always #1 clock = ~clock;

  typedef struct {int locked; int sw; int lp; int err;} ls_t;
  ls_t line_q[$];
  int act_q[$];
  int checks = 0, failures = 0;
  // Model: 0 search, 1 train, 2 locked; stored width/period; previous line low/high lengths.
  int m_state = 0, m_sw = 0, m_lp = 0, m_err = 0, m_pw = 0, m_ph = 0;
  int bp, av;
  logic m_prev = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int exp_err();
`ifdef HSYNC_DECODER_ERRCNT_EN
    return m_err;
`else
    return 0;
`endif
  endfunction

  task automatic chk_zero(input string p);
    chk({p, "_locked"}, Locked, 0);
    chk({p, "_sw"}, SynchWidth, 0);
    chk({p, "_lp"}, LinePeriod, 0);
    chk({p, "_linestart"}, LineStart, 0);
    chk({p, "_active"}, ActiveFlag, 0);
    chk({p, "_xpos"}, xposition, 0);
    chk({p, "_errcnt"}, ErrorCount, 0);
  endtask

  task automatic px(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      PixelClock = 1'b1;
      hsync = v;
      repeat (2) @(negedge clock);
      PixelClock = 1'b0;
      repeat (2) @(negedge clock);
    end
  endtask

  // A sync start judges the previous line, then fixes this line's active pixels.
  task automatic begin_line(input int w, input int h);
    ls_t e;
    bit match;
    int lo;
    if (m_state == 0) m_state = 1;
    else begin
      match = (m_pw == m_sw) && (m_pw + m_ph == m_lp);
      if (m_state == 2 && !match && m_err < 255) m_err++;
      m_sw = m_pw;
      m_lp = m_pw + m_ph;
      m_state = match ? 2 : 1;
      e.locked = (m_state == 2);
      e.sw = m_sw;
      e.lp = m_lp;
      e.err = exp_err();
      line_q.push_back(e);
    end
    if (m_state == 2) begin
      lo = m_sw + bp;
      for (int c = lo; c < lo + av && c < w + h && c < 1023; c++) act_q.push_back(c - lo);
    end
    if (w + h > 1023) begin
      if (m_state == 2 && m_err < 255) m_err++;
      m_state = 0;
    end
    m_pw = w;
    m_ph = h;
    px(1'b0, w);
  endtask

  task automatic run_line(input int w, input int h);
    begin_line(w, h);
    px(1'b1, h);
  endtask

  always @(posedge clock) begin
    #0.5;
    if (reset) begin
      if (LineStart) begin
        if (line_q.size() == 0) chk("ls_unexpected", 1, 0);
        else begin
          ls_t e;
          e = line_q.pop_front();
          chk("ls_locked", Locked, e.locked);
          chk("ls_sw", SynchWidth, e.sw);
          chk("ls_lp", LinePeriod, e.lp);
          chk("ls_errcnt", ErrorCount, e.err);
        end
      end
      if (PixelClock && !m_prev) begin
        if (ActiveFlag) begin
          if (act_q.size() == 0) chk("active_unexpected", 1, 0);
          else chk("xpos", xposition, act_q.pop_front());
        end else chk("xpos_idle", xposition, 0);
      end
    end
    m_prev = PixelClock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int w, h;
    bp = 3;
    av = 5;
    BackPorch = 10'(bp);
    ActiveVideo = 10'(av);
    #5 chk_zero("reset");
    #7 reset = 1'b1;
    px(1'b1, 3);
    repeat (5) run_line(2, 10);
    run_line(3, 10);
    repeat (3) run_line(2, 10);
    begin_line(2, 1030);
    px(1'b1, 1030);
    chk("timeout_locked", Locked, 0);
    chk("timeout_active", ActiveFlag, 0);
    chk("timeout_errcnt", ErrorCount, exp_err());
    repeat (3) run_line(2, 10);
    begin_line(2, 10);
    px(1'b1, bp + 1);
    chk("pre_reset_active", ActiveFlag, (m_state == 2) ? 1 : 0);
    #0.3 reset = 1'b0;
    #0.1 chk_zero("async_reset");
    act_q.delete();
    m_state = 0;
    m_sw = 0;
    m_lp = 0;
    m_err = 0;
    bp = $urandom_range(0, 6);
    av = $urandom_range(1, 10);
    BackPorch = 10'(bp);
    ActiveVideo = 10'(av);
    hsync = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    px(1'b1, 2);
    w = $urandom_range(1, 6);
    h = $urandom_range(4, 25);
    repeat (3) run_line(w, h);
    chk("relock", Locked, 1);
    repeat (25) begin
      w = $urandom_range(1, 6);
      h = $urandom_range(4, 25);
      repeat ($urandom_range(1, 4)) run_line(w, h);
    end
    run_line(1, 5);
    px(1'b1, 3);
    chk("line_q_empty", line_q.size(), 0);
    chk("act_q_empty", act_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
